// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU with a valid/ready handshake on both sides. Logic and
//   arithmetic ops finish in one cycle. Shifts are iterative and move one bit
//   per cycle, so the unit needs no barrel shifter.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request valid; held by requester until in_ready
//   in_ready   unit idle and able to accept a request
//   alu_ctrl   4-bit op code, sampled on accept
//   a, b       operands, sampled on accept; b[SHAMT_W-1:0] is the shift amount
//   out_valid  result presented
//   out_ready  consumer takes the result
//   result     op result, stable while out_valid
//   zero       result == 0
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// SHIFT | iterative shift in progress, cnt = shifts still to do
// DONE  | result presented, waiting for out_ready
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUBA = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] cnt;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               accept;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shift_step;

  assign shamt     = b[SHAMT_W-1:0];
  assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign zero      = (result_q == '0);

  // Shift codes pass a through here; the shifting itself happens in SHIFT.
  always_comb begin
    alu_out = a + b;
    case (alu_ctrl)
      OP_AND:          alu_out = a & b;
      OP_OR:           alu_out = a | b;
      OP_XOR:          alu_out = a ^ b;
      OP_SUB, OP_SUBA: alu_out = a - b;
      OP_SLT:          alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:         alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: alu_out = a;
      default:         alu_out = a + b;
    endcase
  end

  always_comb begin
    shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    case (op_q)
      OP_SLL:  shift_step = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, result_q[WIDTH-1:1]};
      default: shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 4'b0000;
      result_q <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= alu_ctrl;
            result_q <= alu_out;
            if (is_shift && (shamt != '0)) begin
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= shift_step;
          cnt      <= cnt - 1'b1;
          // Terminal count: this edge performs the last shift.
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_r;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Issue one op, measure latency from the accept edge, check, then hand it off.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_r, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    check({nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
    alu_ctrl = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0000_0003;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " result"}, result, exp_r);
    check({nm, " zero"}, {31'b0, zero}, {31'b0, (exp_r == 32'd0)});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " out_valid after handshake"}, {31'b0, out_valid}, 32'd0);
    check({nm, " in_ready after handshake"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'd5,        32'd7,        32'd12,         1,  "ADD 5+7"};
    vecs[1]  = '{4'b0110, 32'd5,        32'd5,        32'd0,          1,  "SUB 5-5"};
    vecs[2]  = '{4'b0110, 32'd3,        32'd5,        32'hFFFF_FFFE,  1,  "SUB 3-5"};
    vecs[3]  = '{4'b1111, 32'd1,        32'd2,        32'd3,          1,  "default 1111"};
    vecs[4]  = '{4'b0100, 32'd6,        32'd2,        32'd4,          1,  "SUB alias"};
    vecs[5]  = '{4'b0111, 32'hFFFF_FFFF, 32'd1,       32'd1,          1,  "SLT -1<1"};
    vecs[6]  = '{4'b1000, 32'hFFFF_FFFF, 32'd1,       32'd0,          1,  "SLTU max<1"};
    vecs[7]  = '{4'b0111, 32'd1,        32'hFFFF_FFFF, 32'd0,         1,  "SLT 1<-1"};
    vecs[8]  = '{4'b1000, 32'd1,        32'hFFFF_FFFF, 32'd1,         1,  "SLTU 1<max"};
    vecs[9]  = '{4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, "XOR"};
    vecs[10] = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, "AND"};
    vecs[11] = '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1, "OR"};
    vecs[12] = '{4'b1011, 32'h8000_0000, 32'd4,       32'hF800_0000,  5,  "SRA by 4"};
    vecs[13] = '{4'b1010, 32'h8000_0000, 32'd4,       32'h0800_0000,  5,  "SRL by 4"};
    vecs[14] = '{4'b1001, 32'h0000_1234, 32'd0,       32'h0000_1234,  1,  "SLL by 0"};
    vecs[15] = '{4'b1001, 32'd1,        32'd31,       32'h8000_0000,  32, "SLL by 31"};
    vecs[16] = '{4'b1011, 32'h8000_0000, 32'h0000_0124, 32'hF800_0000, 5, "SRA shamt masked"};
    vecs[17] = '{4'b0010, 32'hFFFF_FFFF, 32'd1,       32'd0,          1,  "ADD wrap"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    a         = 32'd0;
    b         = 32'd0;
    #12;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].exp_r, vecs[i].exp_lat, vecs[i].nm);
    end

    // out_ready while idle must not disturb anything.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle out_ready in_ready", {31'b0, in_ready}, 32'd1);
    check("idle out_ready out_valid", {31'b0, out_valid}, 32'd0);

    // DONE stall: result held for 3 cycles, in_valid ignored meanwhile.
    @(negedge clk);
    alu_ctrl = 4'b0010;
    a        = 32'd2;
    b        = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0110;
    a        = 32'd9;
    b        = 32'd9;
    for (int i = 0; i < 3; i++) begin
      check("stall out_valid", {31'b0, out_valid}, 32'd1);
      check("stall result", result, 32'd5);
      check("stall zero", {31'b0, zero}, 32'd0);
      check("stall in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("stall ignored in_valid", {31'b0, out_valid}, 32'd0);

    // in_ready low count for SRA by 4 with consumer always ready.
    begin
      int low_cnt;
      int guard;
      @(negedge clk);
      out_ready = 1'b1;
      alu_ctrl  = 4'b1011;
      a         = 32'h8000_0000;
      b         = 32'd4;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      low_cnt  = 0;
      guard    = 0;
      while (!in_ready && guard < 100) begin
        low_cnt++;
        guard++;
        @(posedge clk);
        #1;
      end
      out_ready = 1'b0;
      check("SRA in_ready low cycles", low_cnt, 32'd5);
      check("SRA held result", result, 32'hF800_0000);
    end

    // Reset during a long shift aborts immediately.
    @(negedge clk);
    alu_ctrl = 4'b1001;
    a        = 32'd1;
    b        = 32'd31;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("mid-shift out_valid", {31'b0, out_valid}, 32'd0);
    check("mid-shift in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort result", result, 32'd0);
    check("abort zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b0010, 32'd1, 32'd1, 32'd2, 1, "ADD after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
